// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MADD    = 4'd5,
        MTHI    = 4'd6,
        MTLO    = 4'd7,
        MFHI    = 4'd8,
        MFLO    = 4'd9
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;
    localparam int MD_CNT_W   = 4;

    // Ops that occupy the MDU for a fixed latency and end with a HI/LO commit.
    function automatic logic is_long(input md_op_t op);
        return (op == MULT) || (op == MULTU) || (op == MADD) ||
               (op == DIV)  || (op == DIVU);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable latency down-counter; term flags the final cycle of an operation.
module md_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic             term
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_ctrl.sv
// MDU sequencing controller: issue, latency count, HI/LO commit and ID stall.
// Optional MD_DIV0_SKIP_EN: divide by zero is skipped and reported on div0.
import md_pkg::*;

module md_ctrl #(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT,
    parameter int CNT_W   = MD_CNT_W
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   ex_valid,
    input  md_op_t ex_op,
    input  logic   ex_div0,
    input  logic   id_is_md,
    input  logic   flush,
    output logic   start,
    output md_op_t op_sel,
    output logic   busy,
    output logic   stall,
    output logic   hi_we,
    output logic   lo_we,
    output logic   div0,
    output logic   err
);

    md_state_t        state_q, state_d;
    logic             term, cnt_load, cnt_dec, cnt_clr;
    logic             div_skip, go;
    logic [CNT_W-1:0] load_val;

`ifdef MD_DIV0_SKIP_EN
    assign div_skip = is_div(ex_op) && ex_div0;
`else
    logic unused_div0;
    assign unused_div0 = ex_div0;
    assign div_skip    = 1'b0;
`endif

    assign go       = ex_valid && is_long(ex_op) && !flush && !div_skip;
    assign load_val = is_div(ex_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    assign busy     = (state_q == ST_RUN);
    assign stall    = id_is_md && (busy || start);

    md_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .clr      (cnt_clr),
        .term     (term)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go) state_d = ST_RUN;
            ST_RUN:  if (flush || term) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        div0     = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    start    = 1'b1;
                    cnt_load = 1'b1;
                end
                if (ex_valid && !flush) begin
                    hi_we = (ex_op == MTHI);
                    lo_we = (ex_op == MTLO);
                    div0  = is_long(ex_op) && div_skip;
                end
            end
            ST_RUN: begin
                // A flush aborts the op, including a commit due this cycle.
                if (flush) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    hi_we   = term;
                    lo_we   = term;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            op_sel <= MD_NONE;
        else if (start)
            op_sel <= ex_op;
    end

    // Any MDU op arriving while busy is ignored but latched as an error.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (busy && ex_valid && (ex_op != MD_NONE))
            err <= 1'b1;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed plus randomized bench for md_ctrl against an absolute-time reference model.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;
`ifdef MD_DIV0_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic   clk = 1'b0, reset = 1'b1;
    logic   ex_valid = 1'b0, ex_div0 = 1'b0, id_is_md = 1'b0, flush = 1'b0;
    md_op_t ex_op = MD_NONE;
    logic   start, busy, stall, hi_we, lo_we, div0, err;
    md_op_t op_sel;

    int     checks = 0, failures = 0;
    int     cyc = 0, t0 = 0, commit_cyc = -1;
    bit     m_inflight = 1'b0, m_err = 1'b0;
    int     m_commit_at = 0;
    md_op_t m_op = MD_NONE;

    md_ctrl #(.MUL_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_div0(ex_div0), .id_is_md(id_is_md), .flush(flush),
        .start(start), .op_sel(op_sel), .busy(busy), .stall(stall),
        .hi_we(hi_we), .lo_we(lo_we), .div0(div0), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check combinational/registered outputs, advance model.
    task automatic step(input bit v, input md_op_t op, input bit d0, input bit id,
                        input bit f, input bit r);
        bit idle, lng, isd, st_e, d0_e, cm_e, hi_e, lo_e;
        ex_valid = v; ex_op = op; ex_div0 = d0; id_is_md = id; flush = f; reset = r;
        #3;
        idle = !m_inflight;
        lng  = op inside {MULT, MULTU, MADD, DIV, DIVU};
        isd  = op inside {DIV, DIVU};
        st_e = idle && v && lng && !f && !(SKIP && isd && d0);
        d0_e = idle && v && isd && d0 && !f && SKIP;
        cm_e = m_inflight && (cyc == m_commit_at) && !f;
        hi_e = cm_e || (idle && v && !f && op == MTHI);
        lo_e = cm_e || (idle && v && !f && op == MTLO);
        chk("start",  start,  st_e);
        chk("busy",   busy,   m_inflight);
        chk("stall",  stall,  id && (m_inflight || st_e));
        chk("hi_we",  hi_we,  hi_e);
        chk("lo_we",  lo_we,  lo_e);
        chk("div0",   div0,   d0_e);
        chk("err",    err,    m_err);
        chk("op_sel", op_sel, m_op);
        if (hi_we === 1'b1 && lo_we === 1'b1) commit_cyc = cyc;
        @(posedge clk);
        if (r) begin
            m_inflight = 1'b0; m_err = 1'b0; m_op = MD_NONE;
        end else begin
            if (m_inflight && v && op != MD_NONE) m_err = 1'b1;
            if (m_inflight && (f || cyc == m_commit_at)) m_inflight = 1'b0;
            else if (st_e) begin
                m_inflight  = 1'b1;
                m_commit_at = cyc + (isd ? DL : ML);
                m_op        = op;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, then MULT at cycle 2 commits at cycle 7.
        step(0, MD_NONE, 0, 0, 0, 0);
        step(0, MD_NONE, 0, 0, 0, 0);
        step(1, MULT, 0, 0, 0, 0);
        repeat (7) step(0, MD_NONE, 0, 0, 0, 0);
        chk("mult_commit_cycle", commit_cyc, 7);
        // DIV with an MDU op sitting in ID throughout.
        t0 = cyc;
        step(1, DIV, 0, 1, 0, 0);
        repeat (11) step(0, MD_NONE, 0, 1, 0, 0);
        chk("div_commit_cycle", commit_cyc, t0 + DL);
        // MTHI while idle, then MULTU collides with an in-flight MULT.
        step(1, MTHI, 0, 0, 0, 0);
        t0 = cyc;
        step(1, MULT, 0, 0, 0, 0);
        step(0, MD_NONE, 0, 0, 0, 0);
        step(1, MULTU, 0, 1, 0, 0);
        repeat (6) step(0, MD_NONE, 0, 0, 0, 0);
        chk("err_sticky", err, 1);
        chk("collide_commit_cycle", commit_cyc, t0 + ML);
        // Flush aborts a MULT; a new MULT starts the next cycle.
        t0 = cyc;
        step(1, MULT, 0, 0, 0, 0);
        repeat (2) step(0, MD_NONE, 0, 0, 0, 0);
        step(0, MD_NONE, 0, 0, 1, 0);
        step(1, MULT, 0, 0, 0, 0);
        repeat (6) step(0, MD_NONE, 0, 0, 0, 0);
        chk("flush_restart_commit", commit_cyc, t0 + 4 + ML);
        // Divide by zero.
        t0 = cyc; commit_cyc = -1;
        step(1, DIVU, 1, 0, 0, 0);
        repeat (11) step(0, MD_NONE, 0, 0, 0, 0);
        chk("div0_commit", commit_cyc, SKIP ? -1 : t0 + DL);
        // Reset in the middle of a DIV: never commits, err cleared.
        commit_cyc = -1;
        step(1, DIV, 0, 0, 0, 0);
        repeat (4) step(0, MD_NONE, 0, 0, 0, 0);
        step(0, MD_NONE, 0, 0, 0, 1);
        repeat (12) step(0, MD_NONE, 0, 0, 0, 0);
        chk("reset_no_commit", commit_cyc, -1);
        chk("reset_err_clear", err, 0);
        // Randomized traffic.
        repeat (800) begin
            step($urandom_range(0, 1) == 1, md_op_t'($urandom_range(0, 9)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
